// File: rtl/vla_pkg.sv
// vla_pkg: shared opcode, state and strobe definitions for the VLA sequencer
package vla_pkg;
    localparam int PHASE_W = 3;
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;
    localparam logic [2:0] ALU_LO = OP_ADD;
    localparam logic [2:0] ALU_HI = OP_LDA;
    typedef enum logic [1:0] {RUN, HALTED, PAUSED} state_t;
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic halt;
        logic ld_pc;
        logic data_e;
        logic ld_ac;
        logic wr;
    } strobes_t;
endpackage

// File: rtl/vla_decode.sv
// vla_decode: combinational phase/opcode/zero to datapath strobe decoder
// phase, opcode, zero in; strobes (9 datapath strobes), illegal (opcode >= 8), is_alu out
module vla_decode
    import vla_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic [PHASE_W-1:0]  phase,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output strobes_t            strobes,
    output logic                illegal,
    output logic                is_alu
);
    logic [2:0] op;
    logic is_hlt, is_skz, is_sto, is_jmp;
    always_comb begin
        op      = opcode[2:0];
        illegal = 32'(opcode) > 32'd7;
        is_alu  = !illegal && op >= ALU_LO && op <= ALU_HI;
        is_hlt  = illegal || op == OP_HLT;
        is_skz  = !illegal && op == OP_SKZ;
        is_sto  = !illegal && op == OP_STO;
        is_jmp  = !illegal && op == OP_JMP;
        strobes = '0;
        case (phase)
            3'd0: strobes.sel = 1'b1;
            3'd1: begin
                strobes.sel = 1'b1;
                strobes.rd  = 1'b1;
            end
            3'd2, 3'd3: begin
                strobes.sel   = 1'b1;
                strobes.rd    = 1'b1;
                strobes.ld_ir = 1'b1;
            end
            3'd4: begin
                strobes.inc_pc = 1'b1;
                strobes.halt   = is_hlt;
            end
            3'd5: strobes.rd = is_alu;
            3'd6: begin
                strobes.rd     = is_alu;
                strobes.inc_pc = is_skz && zero;
                strobes.ld_pc  = is_jmp;
                strobes.data_e = is_sto;
            end
            default: begin
                strobes.rd     = is_alu;
                strobes.ld_pc  = is_jmp;
                strobes.data_e = is_sto;
                strobes.ld_ac  = is_alu;
                strobes.wr     = is_sto;
            end
        endcase
    end
endmodule

// File: rtl/vla_sequencer.sv
// vla_sequencer: 8-phase VLA instruction sequencer with wait states, watchdog, halt/pause and step
// clk, rst (sync, active-high); opcode, zero, mem_ready, step_en, resume in
// sel..wr datapath strobes, phase, instr_done, illegal, bus_err out
module vla_sequencer
    import vla_pkg::*;
#(
    parameter int OPCODE_W   = 3,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                step_en,
    input  logic                resume,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                halt,
    output logic                ld_pc,
    output logic                data_e,
    output logic                ld_ac,
    output logic                wr,
    output logic [PHASE_W-1:0]  phase,
    output logic                instr_done,
    output logic                illegal,
    output logic                bus_err
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 2);
    state_t state, state_nxt;
    logic [PHASE_W-1:0] phase_q, phase_nxt;
    logic [CNT_W-1:0] stall, stall_nxt;
    logic ill_q, ill_nxt, bus_q, bus_nxt;
    logic run, access, adv, wd, dec_ill, dec_alu;
    strobes_t dec, out;
    vla_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .phase   (phase_q),
        .opcode  (opcode),
        .zero    (zero),
        .strobes (dec),
        .illegal (dec_ill),
        .is_alu  (dec_alu)
    );
    always_comb begin
        run    = state == RUN;
        // is_alu covers the rd of phases 5-7; phases 1-3 always fetch
        access = dec.rd | dec.wr | (dec_alu && phase_q >= 3'd5);
        adv    = run && (!access || mem_ready);
        // fires on the stall cycle that would bring the counter to WAIT_LIMIT
        wd     = run && !adv && WAIT_LIMIT != 0 && 32'(stall) + 32'd1 == WAIT_LIMIT;
        out       = (!rst && run) ? dec : '0;
        out.halt  = !rst && (run ? dec.halt : state == HALTED);
        instr_done = !rst && adv && phase_q == 3'd7;
        state_nxt = state;
        phase_nxt = phase_q;
        stall_nxt = stall;
        ill_nxt   = ill_q;
        bus_nxt   = bus_q;
        if (!run) begin
            if (resume) begin
                state_nxt = RUN;
                phase_nxt = '0;
                stall_nxt = '0;
                ill_nxt   = 1'b0;
                bus_nxt   = 1'b0;
            end
        end else if (wd) begin
            state_nxt = HALTED;
            bus_nxt   = 1'b1;
        end else if (!adv) begin
            stall_nxt = stall + CNT_W'(1);
        end else begin
            stall_nxt = '0;
            if (dec.halt) begin
                state_nxt = HALTED;
                ill_nxt   = dec_ill;
            end else if (phase_q == 3'd7 && step_en) begin
                state_nxt = PAUSED;
                phase_nxt = '0;
            end else begin
                phase_nxt = phase_q + 3'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            phase_q <= '0;
            stall   <= '0;
            ill_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase_q <= phase_nxt;
            stall   <= stall_nxt;
            ill_q   <= ill_nxt;
            bus_q   <= bus_nxt;
        end
    end
    assign {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = out;
    assign phase   = phase_q;
    assign illegal = ill_q;
    assign bus_err = bus_q;
endmodule

// File: tb/tb_vla_sequencer.sv
// tb_vla_sequencer: scoreboard bench for vla_sequencer (OPCODE_W=4, WAIT_LIMIT=4)
module tb_vla_sequencer;
    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1, step_en = 1'b0, resume = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, instr_done, illegal, bus_err;
    logic [2:0] phase;
    int errors = 0, checks = 0;
    logic [14:0] q_exp[$], q_msk[$];
    logic [1:0] m_st = 2'd0;
    logic [2:0] m_ph = 3'd0;
    int m_stall = 0;
    logic m_ill = 1'b0, m_bus = 1'b0, m_done = 1'b0, g_se = 1'b0;

    vla_sequencer #(.OPCODE_W(4), .WAIT_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .step_en(step_en), .resume(resume), .sel(sel), .rd(rd), .ld_ir(ld_ir),
        .inc_pc(inc_pc), .halt(halt), .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac),
        .wr(wr), .phase(phase), .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // bit order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
    function automatic logic [8:0] ref_dec(input logic [2:0] ph, input logic [3:0] op, input logic z);
        logic alu, hlt, skz, sto, jmp;
        logic [8:0] r;
        alu = op >= 4'd2 && op <= 4'd5;
        hlt = op == 4'd0 || op > 4'd7;
        skz = op == 4'd1;
        sto = op == 4'd6;
        jmp = op == 4'd7;
        case (ph)
            3'd0: r = 9'b100000000;
            3'd1: r = 9'b110000000;
            3'd2, 3'd3: r = 9'b111000000;
            3'd4: r = {3'b000, 1'b1, hlt, 4'b0000};
            3'd5: r = {1'b0, alu, 7'b0};
            3'd6: r = {1'b0, alu, 1'b0, skz & z, 1'b0, jmp, sto, 2'b00};
            default: r = {1'b0, alu, 3'b000, jmp, sto, alu, sto};
        endcase
        return r;
    endfunction

    task automatic cyc(input logic [3:0] op, input logic z, input logic mr, input logic se,
                       input logic res, input logic r);
        logic [8:0] sd, s;
        logic adv;
        logic [14:0] e, m, got;
        opcode = op; zero = z; mem_ready = mr; step_en = se; resume = res; rst = r;
        sd = ref_dec(m_ph, op, z);
        adv = m_st == 2'd0 && (!(sd[7] | sd[0]) || mr);
        m_done = !r && adv && m_ph == 3'd7;
        s = (r || m_st == 2'd2) ? 9'd0 : (m_st == 2'd1) ? 9'b000010000 : sd;
        q_exp.push_back({s, m_ph, m_done, m_ill, m_bus});
        q_msk.push_back(r ? 15'b111111111_000_1_00 : 15'h7fff);
        #1;
        got = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase, instr_done, illegal, bus_err};
        e = q_exp.pop_front();
        m = q_msk.pop_front();
        check("outs", 32'(got & m), 32'(e & m));
        if (r) begin
            m_st = 2'd0; m_ph = 3'd0; m_stall = 0; m_ill = 1'b0; m_bus = 1'b0;
        end else if (m_st != 2'd0) begin
            if (res) begin
                m_st = 2'd0; m_ph = 3'd0; m_stall = 0; m_ill = 1'b0; m_bus = 1'b0;
            end
        end else if (!adv) begin
            if (m_stall + 1 == 4) begin
                m_st = 2'd1; m_bus = 1'b1;
            end else m_stall++;
        end else begin
            m_stall = 0;
            if (m_ph == 3'd4 && (op == 4'd0 || op > 4'd7)) begin
                m_st = 2'd1; m_ill = op > 4'd7;
            end else if (m_ph == 3'd7 && se) begin
                m_st = 2'd2; m_ph = 3'd0;
            end else m_ph = m_ph + 3'd1;
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input logic z,
                             input int stall_ph, input int stall_n, input int exp_len);
        int n = 0, k = 0;
        logic mr;
        m_done = 1'b0;
        while (!m_done && n < 40) begin
            mr = 1'b1;
            if (m_ph == stall_ph && k < stall_n) begin
                mr = 1'b0;
                k++;
            end
            cyc(op, z, mr, g_se, 1'b0, 1'b0);
            n++;
        end
        check(tag, n, exp_len);
    endtask

    task automatic run_until_halt(input string tag, input logic [3:0] op, input int stall_ph, input int exp_len);
        int n = 0;
        while (m_st != 2'd1 && n < 40) begin
            cyc(op, 1'b0, !(m_ph == stall_ph), 1'b0, 1'b0, 1'b0);
            n++;
        end
        check(tag, n, exp_len);
    endtask

    initial begin
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_instr("len_lda", 4'd5, 1'b0, -1, 0, 8);
        run_instr("len_add", 4'd2, 1'b0, -1, 0, 8);
        run_instr("len_sto", 4'd6, 1'b0, -1, 0, 8);
        run_instr("len_jmp", 4'd7, 1'b0, -1, 0, 8);
        run_instr("len_skz1", 4'd1, 1'b1, -1, 0, 8);
        run_instr("len_skz0", 4'd1, 1'b0, -1, 0, 8);
        run_instr("len_stall", 4'd5, 1'b0, 1, 3, 11);
        run_until_halt("len_wd", 4'd5, 5, 9);
        repeat (2) cyc(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bus_err", 32'(bus_err), 32'd1);
        cyc(4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("bus_clr", 32'({bus_err, phase}), 32'd0);
        run_instr("len_after_wd", 4'd5, 1'b0, -1, 0, 8);
        run_until_halt("len_hlt", 4'd0, -1, 5);
        repeat (2) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ill_hlt", 32'(illegal), 32'd0);
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_instr("len_after_hlt", 4'd3, 1'b0, -1, 0, 8);
        run_until_halt("len_ill", 4'd9, -1, 5);
        repeat (2) cyc(4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ill_9", 32'(illegal), 32'd1);
        cyc(4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_instr("len_after_ill", 4'd4, 1'b0, -1, 0, 8);
        g_se = 1'b1;
        run_instr("len_step1", 4'd2, 1'b0, -1, 0, 8);
        repeat (3) cyc(4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_instr("len_step2", 4'd6, 1'b0, -1, 0, 8);
        cyc(4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        g_se = 1'b0;
        run_instr("len_step_off", 4'd7, 1'b0, -1, 0, 8);
        repeat (6) cyc(4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_instr("len_after_rst", 4'd6, 1'b0, -1, 0, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vla_sequencer.md
# vla_sequencer

Parametrised instruction sequencer for the VLA CPU. It owns the 8-phase instruction counter and decodes phase, opcode and the accumulator zero flag into the nine datapath control strobes. Beyond the fixed 8-cycle decoder, it adds memory wait states, a stall watchdog, a sticky halt state with resume, single-step mode and illegal-opcode detection. It sits between the instruction register / ALU zero flag and the datapath (PC, IR, ACC, memory).

## Interface
- OPCODE_W, 3: opcode width, must be ≥3. Values 0–7 are the VLA ISA; values ≥8 are illegal.
- WAIT_LIMIT, 15: maximum consecutive stall cycles before a bus error. 0 disables the watchdog.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  current IR opcode.
- zero  in  1  accumulator-zero flag. Sampled combinationally in phase 6.
- mem_ready  in  1  memory has completed the current rd/wr access.
- step_en  in  1  pause after every instruction.
- resume  in  1  one-cycle pulse that leaves HALTED or PAUSED.
- sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr  out  1 each  datapath strobes.
- phase  out  3  current phase 0–7.
- instr_done  out  1  pulse on the cycle phase 7 completes.
- illegal  out  1  sticky; illegal opcode caused the current halt.
- bus_err  out  1  sticky; watchdog caused the current halt.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALU class is ADD/AND/XOR/LDA (2–5). Illegal opcodes decode as HLT.
- Strobe decode in RUN:
  - phase 0: sel.
  - phase 1: sel, rd.
  - phases 2–3: sel, rd, ld_ir.
  - phase 4: inc_pc; halt if HLT or illegal.
  - phase 5: rd if ALU.
  - phase 6: rd if ALU; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
  - phase 7: rd if ALU; ld_pc if JMP; data_e if STO; ld_ac if ALU; wr if STO.
- States are RUN, HALTED and PAUSED.
- Reset: state=RUN, phase=0, counter, illegal and bus_err cleared. While rst=1, all strobes and instr_done are 0.
- Advance rule (RUN): phase increments (7 wraps to 0) when no rd/wr is asserted this cycle, or mem_ready=1. Otherwise the phase and all strobes hold and the stall counter increments.
- Stall counter clears on every advance.
- Watchdog: when the stall counter reaches WAIT_LIMIT while still stalled, next state=HALTED, bus_err=1.
- HLT/illegal: the phase-4 cycle advances normally. The next state is HALTED instead of phase 5. illegal is set if the opcode was ≥8.
- Step: on phase-7 completion with step_en=1, next state=PAUSED, phase=0.
- In HALTED: halt=1, all other strobes 0, phase reads the frozen value.
- In PAUSED: all strobes 0, phase=0.
- resume in HALTED or PAUSED: next state=RUN, phase=0, illegal and bus_err cleared. PC was already advanced in phase 4, so execution continues at the next instruction.
- resume in RUN is ignored.

## Timing
- Strobes are combinational from registered state/phase plus the opcode and zero inputs. There is no output register.
- With mem_ready=1 permanently, an instruction takes exactly 8 cycles, with phase = 0..7.
- Each stall cycle adds 1 cycle.
- instr_done is high in the phase-7 cycle in which the advance occurs.
- Priority: rst > watchdog > HLT/illegal > step pause > normal advance.
- resume is sampled only in HALTED/PAUSED. RUN is entered on the following edge.
- If step_en stays 1, the sequencer runs one instruction per resume.
- Reset mid-instruction or mid-stall: phase returns to 0 on the next edge. No strobe is asserted during the rst cycle.
- Opcode must be stable from phase 4 to phase 7. The zero input must be stable in phase 6.

## Structure
- Shared package vla_pkg: opcode localparams, the ALU-class range, the state encoding (RUN/HALTED/PAUSED) and the phase width.
- Sub-module vla_decode: purely combinational phase/opcode/zero → 9-bit strobe vector, plus the illegal and is_alu flags.
- vla_sequencer holds the state register, phase counter, stall counter and sticky flags.

## Test plan
- Program LDA, ADD, STO, JMP with mem_ready=1 → each instruction takes 8 cycles.
  - STO: phase 7 shows data_e=1 and wr=1.
  - JMP: ld_pc=1 in phases 6–7.
  - ALU instructions: ld_ac=1 only in phase 7.
- SKZ with zero=1, then zero=0 → inc_pc in phase 6 only when zero=1. inc_pc is always set in phase 4.
- LDA with mem_ready low for 3 cycles in phase 1 → phase holds at 1 with sel/rd asserted. The instruction takes 11 cycles.
- WAIT_LIMIT=4 with mem_ready stuck low in phase 5 → bus_err=1 and halt=1 after 4 stall cycles. A resume pulse gives phase 0 in RUN with bus_err=0.
- Opcode 0 and, with OPCODE_W=4, opcode 9 → halt in phase 4, then HALTED.
  - illegal=0 for opcode 0 and 1 for opcode 9.
  - resume restarts at phase 0.
- step_en=1 → PAUSED after instr_done. Outputs stay 0 until resume, then one instruction runs.
- Reset asserted in phase 6 of a STO → no wr. The sequencer restarts at phase 0 one cycle after rst falls.
